// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC channel sequencer.
// Also holds a lowest-set-bit helper for masks up to the 15-channel limit.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_NEXT
  } state_t;

  localparam int unsigned CH_W   = 4;
  localparam int unsigned MAX_CH = 15;
  localparam logic [CH_W-1:0] CH_NONE = 4'hF;

  // Lowest set bit of a zero-extended channel mask; CH_NONE when empty.
  function automatic logic [CH_W-1:0] lowest_set(input logic [MAX_CH-1:0] m);
    logic [CH_W-1:0] res;
    res = CH_NONE;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (m[i]) res = CH_W'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/next_channel_finder.sv
// Combinational search over a channel mask: lowest set bit overall and
// lowest set bit strictly above the current channel.
module next_channel_finder
  import adc_seq_pkg::*;
#(
  parameter int unsigned NUM_CH = 10
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  output logic [CH_W-1:0]   next,
  output logic              found,
  output logic [CH_W-1:0]   first
);

  // Scan downwards so the lowest qualifying index is the last one written.
  always_comb begin
    next  = CH_NONE;
    found = 1'b0;
    first = CH_NONE;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first = CH_W'(i);
        if (CH_W'(i) > cur) begin
          next  = CH_W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_channel_sequencer.sv
// Round-robin ADC channel scanner: requests each enabled channel, captures the
// matching sample into a per-channel bank, and flags channels that time out.
module adc_channel_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned NUM_CH   = 10,
  parameter int unsigned SAMPLE_W = 10,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic [NUM_CH-1:0]            enable_mask,
  input  logic                         clear_err,
  input  logic                         new_sample,
  input  logic [SAMPLE_W-1:0]          sample,
  input  logic [CH_W-1:0]              sample_channel,
  output logic [CH_W-1:0]              channel,
  output logic                         busy,
  output logic                         sample_valid,
  output logic [SAMPLE_W-1:0]          sample_out,
  output logic [CH_W-1:0]              sample_ch_out,
  output logic                         frame_done,
  output logic [NUM_CH-1:0]            timeout_err,
  output logic [NUM_CH*SAMPLE_W-1:0]   sample_bank
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t state_q, state_d;

  logic [NUM_CH-1:0]          frame_mask_q, frame_mask_d;
  logic [TMR_W-1:0]           timer_q, timer_d;
  logic [CH_W-1:0]            channel_d;
  logic                       sample_valid_d;
  logic [SAMPLE_W-1:0]        sample_out_d;
  logic [CH_W-1:0]            sample_ch_out_d;
  logic                       frame_done_d;
  logic [NUM_CH-1:0]          timeout_err_d;
  logic [NUM_CH*SAMPLE_W-1:0] sample_bank_d;

  logic              start_c;
  logic              match_c;
  logic              expire_c;
  logic [NUM_CH-1:0] finder_mask_c;
  logic [CH_W-1:0]   next_ch_c;
  logic [CH_W-1:0]   first_ch_c;
  logic              found_c;

  assign start_c  = run && (|enable_mask);
  assign match_c  = new_sample && (sample_channel == channel);
  assign expire_c = (timer_q == TMR_LAST);

  // In IDLE the finder looks at the live enables to pick the first channel;
  // mid-frame it walks the mask latched at the frame boundary.
  assign finder_mask_c = (state_q == S_IDLE) ? enable_mask : frame_mask_q;

  next_channel_finder #(
    .NUM_CH (NUM_CH)
  ) u_finder (
    .mask  (finder_mask_c),
    .cur   (channel),
    .next  (next_ch_c),
    .found (found_c),
    .first (first_ch_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_c) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (match_c || expire_c) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (found_c || start_c) state_d = S_WAIT;
        else                    state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    frame_mask_d    = frame_mask_q;
    timer_d         = timer_q;
    channel_d       = channel;
    sample_valid_d  = 1'b0;
    frame_done_d    = 1'b0;
    sample_out_d    = sample_out;
    sample_ch_out_d = sample_ch_out;
    sample_bank_d   = sample_bank;
    timeout_err_d   = clear_err ? '0 : timeout_err;

    unique case (state_q)
      S_IDLE: begin
        channel_d = CH_NONE;
        timer_d   = '0;
        if (start_c) begin
          frame_mask_d = enable_mask;
          channel_d    = first_ch_c;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        if (match_c) begin
          // A match on the expiry cycle still wins: no error flag.
          sample_valid_d  = 1'b1;
          sample_out_d    = sample;
          sample_ch_out_d = channel;
          for (int i = 0; i < NUM_CH; i++) begin
            if (CH_W'(i) == channel) sample_bank_d[i*SAMPLE_W +: SAMPLE_W] = sample;
          end
        end else if (expire_c) begin
          // Set after the clear so a same-edge timeout survives clear_err.
          for (int i = 0; i < NUM_CH; i++) begin
            if (CH_W'(i) == channel) timeout_err_d[i] = 1'b1;
          end
        end
      end
      S_NEXT: begin
        timer_d = '0;
        if (found_c) begin
          channel_d = next_ch_c;
        end else begin
          frame_done_d = 1'b1;
          if (start_c) begin
            frame_mask_d = enable_mask;
            channel_d    = lowest_set(MAX_CH'(enable_mask));
          end else begin
            channel_d = CH_NONE;
          end
        end
      end
      default: begin
        channel_d = CH_NONE;
        timer_d   = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_mask_q  <= '0;
      timer_q       <= '0;
      channel       <= CH_NONE;
      busy          <= 1'b0;
      sample_valid  <= 1'b0;
      frame_done    <= 1'b0;
      sample_out    <= '0;
      sample_ch_out <= '0;
      timeout_err   <= '0;
      sample_bank   <= '0;
    end else begin
      frame_mask_q  <= frame_mask_d;
      timer_q       <= timer_d;
      channel       <= channel_d;
      busy          <= (state_d != S_IDLE);
      sample_valid  <= sample_valid_d;
      frame_done    <= frame_done_d;
      sample_out    <= sample_out_d;
      sample_ch_out <= sample_ch_out_d;
      timeout_err   <= timeout_err_d;
      sample_bank   <= sample_bank_d;
    end
  end

endmodule
